// File: rtl/m6502_bus_pkg.sv
// Shared definitions for the 6502 bus arbiter: FSM states, port IDs and the
// round-robin pick used when both request slots compete for the memory bus.
package m6502_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    // Both pending: the port not granted last wins. Otherwise the only
    // pending port wins.
    function automatic logic rr_pick(input logic cpu_pend,
                                     input logic dma_pend,
                                     input logic last_grant);
        if (cpu_pend && dma_pend) begin
            return ~last_grant;
        end else if (cpu_pend) begin
            return PORT_CPU;
        end else begin
            return PORT_DMA;
        end
    endfunction

endpackage

// File: rtl/m6502_bus_req_slot.sv
// One pending-request slot: holds address, write data, access type and a
// valid flag for a single requester until the arbiter retires it.
module m6502_bus_req_slot (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        i_load,
    input  logic        i_clear,
    input  logic [15:0] i_addr,
    input  logic [7:0]  i_data,
    input  logic        i_we,
    output logic        o_valid,
    output logic [15:0] o_addr,
    output logic [7:0]  o_data,
    output logic        o_we
);

    logic        r_valid;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_we;

    // Capture a new request, or drop the slot when its access retires.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (!reset_n) begin
            // NOTE: payload is reset too; it is a handful of flops, not a RAM,
            // and a clean value keeps the bus quiet after reset.
            r_valid <= 1'b0;
            r_addr  <= 16'h0000;
            r_data  <= 8'h00;
            r_we    <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
            r_we    <= i_we;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_addr  = r_addr;
    assign o_data  = r_data;
    assign o_we    = r_we;

endmodule

// File: rtl/m6502_bus_arbiter.sv
// Two-port (CPU, DMA) arbiter in front of a single memory bus. Each port
// parks its request in a slot; a small FSM issues one access at a time,
// waits out the read latency and re-arbitrates round-robin on completion.
module m6502_bus_arbiter
    import m6502_bus_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rd_req,
    input  logic        cpu_wr_en,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_ready,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_addr,
    input  logic [7:0]  dma_wr_data,
    output logic [7:0]  dma_rd_data,
    output logic        dma_ack,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wr_data,
    output logic        mem_rd_req,
    output logic        mem_wr_en,
    input  logic [7:0]  mem_rd_data,
    input  logic        mem_ready
);

    localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

    state_t      r_state;
    logic        r_last_grant;
    logic [2:0]  r_lat_cnt;
    logic        r_cpu_ready;
    logic        r_dma_ack;
    logic [7:0]  r_cpu_rd_data;
    logic [7:0]  r_dma_rd_data;
    logic [15:0] r_mem_addr;
    logic [7:0]  r_mem_wr_data;
    logic        r_mem_rd_req;
    logic        r_mem_wr_en;

    logic        w_cpu_cap, w_dma_cap;
    logic        w_cpu_clr, w_dma_clr;
    logic        w_cpu_valid, w_dma_valid;
    logic [15:0] w_cpu_addr_q, w_dma_addr_q;
    logic [7:0]  w_cpu_data_q, w_dma_data_q;
    logic        w_cpu_we_q, w_dma_we_q;
    logic        w_cpu_pend, w_dma_pend;
    logic [15:0] w_cpu_addr, w_dma_addr;
    logic [7:0]  w_cpu_data, w_dma_data;
    logic        w_cpu_we, w_dma_we;
    logic        w_done;
    logic        w_go;
    logic        w_go_port;
    logic [15:0] w_go_addr;
    logic [7:0]  w_go_data;
    logic        w_go_we;

    // A CPU strobe is only taken while nothing of the CPU's is outstanding;
    // DMA is held off for the ack cycle so a level request is not double-taken.
    assign w_cpu_cap = (cpu_rd_req | cpu_wr_en) & r_cpu_ready;
    assign w_dma_cap = dma_req & ~w_dma_valid & ~r_dma_ack;

    // Writes retire at acceptance, reads when the latency countdown expires.
    assign w_done    = ((r_state == ST_ISSUE) && mem_ready && r_mem_wr_en) ||
                       ((r_state == ST_WAIT) && (r_lat_cnt == 3'd0));
    assign w_cpu_clr = w_done & (r_last_grant == PORT_CPU);
    assign w_dma_clr = w_done & (r_last_grant == PORT_DMA);

    // cpu_wr_en alone decides the type, so a read+write strobe is a write.
    m6502_bus_req_slot u_cpu_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_cpu_cap),
        .i_clear (w_cpu_clr),
        .i_addr  (cpu_addr),
        .i_data  (cpu_wr_data),
        .i_we    (cpu_wr_en),
        .o_valid (w_cpu_valid),
        .o_addr  (w_cpu_addr_q),
        .o_data  (w_cpu_data_q),
        .o_we    (w_cpu_we_q)
    );

    m6502_bus_req_slot u_dma_slot (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_dma_cap),
        .i_clear (w_dma_clr),
        .i_addr  (dma_addr),
        .i_data  (dma_wr_data),
        .i_we    (dma_we),
        .o_valid (w_dma_valid),
        .o_addr  (w_dma_addr_q),
        .o_data  (w_dma_data_q),
        .o_we    (w_dma_we_q)
    );

    // A request being captured this edge is visible to arbitration at once,
    // so a lone request is granted without an extra idle cycle.
    assign w_cpu_pend = w_cpu_valid | w_cpu_cap;
    assign w_dma_pend = w_dma_valid | w_dma_cap;
    assign w_cpu_addr = w_cpu_valid ? w_cpu_addr_q : cpu_addr;
    assign w_cpu_data = w_cpu_valid ? w_cpu_data_q : cpu_wr_data;
    assign w_cpu_we   = w_cpu_valid ? w_cpu_we_q   : cpu_wr_en;
    assign w_dma_addr = w_dma_valid ? w_dma_addr_q : dma_addr;
    assign w_dma_data = w_dma_valid ? w_dma_data_q : dma_wr_data;
    assign w_dma_we   = w_dma_valid ? w_dma_we_q   : dma_we;

    // Decide whether a new access is granted this edge, and to whom.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        w_go      = 1'b0;
        w_go_port = r_last_grant;
        if (r_state == ST_IDLE) begin
            if (w_cpu_pend || w_dma_pend) begin
                w_go      = 1'b1;
                w_go_port = rr_pick(w_cpu_pend, w_dma_pend, r_last_grant);
            end
        end else if (w_done) begin
            // The retiring port is excluded; only the other one can follow.
            if (r_last_grant == PORT_CPU) begin
                w_go      = w_dma_pend;
                w_go_port = PORT_DMA;
            end else begin
                w_go      = w_cpu_pend;
                w_go_port = PORT_CPU;
            end
        end
        w_go_addr = (w_go_port == PORT_CPU) ? w_cpu_addr : w_dma_addr;
        w_go_data = (w_go_port == PORT_CPU) ? w_cpu_data : w_dma_data;
        w_go_we   = (w_go_port == PORT_CPU) ? w_cpu_we   : w_dma_we;
    end

    // Arbiter FSM with all bus and completion outputs registered.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_last_grant  <= PORT_DMA;
            r_lat_cnt     <= 3'd0;
            r_cpu_ready   <= 1'b1;
            r_dma_ack     <= 1'b0;
            r_cpu_rd_data <= 8'h00;
            r_dma_rd_data <= 8'h00;
            r_mem_addr    <= 16'h0000;
            r_mem_wr_data <= 8'h00;
            r_mem_rd_req  <= 1'b0;
            r_mem_wr_en   <= 1'b0;
        end else begin
            r_dma_ack <= 1'b0;
            if (w_cpu_cap) begin
                r_cpu_ready <= 1'b0;
            end

            if (w_done) begin
                if (r_last_grant == PORT_CPU) begin
                    r_cpu_ready <= 1'b1;
                    if (r_state == ST_WAIT) begin
                        r_cpu_rd_data <= mem_rd_data;
                    end
                end else begin
                    r_dma_ack <= 1'b1;
                    if (r_state == ST_WAIT) begin
                        r_dma_rd_data <= mem_rd_data;
                    end
                end
            end

            case (r_state)
                ST_IDLE: begin
                end
                ST_ISSUE: begin
                    if (mem_ready) begin
                        r_mem_rd_req <= 1'b0;
                        r_mem_wr_en  <= 1'b0;
                        if (r_mem_wr_en) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state   <= ST_WAIT;
                            r_lat_cnt <= LAT_LAST;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 3'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // A grant overrides the fall-back state chosen above.
            if (w_go) begin
                r_state       <= ST_ISSUE;
                r_last_grant  <= w_go_port;
                r_mem_addr    <= w_go_addr;
                r_mem_wr_data <= w_go_data;
                r_mem_wr_en   <= w_go_we;
                r_mem_rd_req  <= ~w_go_we;
            end
        end
    end

    assign cpu_ready   = r_cpu_ready;
    assign cpu_rd_data = r_cpu_rd_data;
    assign dma_ack     = r_dma_ack;
    assign dma_rd_data = r_dma_rd_data;
    assign mem_addr    = r_mem_addr;
    assign mem_wr_data = r_mem_wr_data;
    assign mem_rd_req  = r_mem_rd_req;
    assign mem_wr_en   = r_mem_wr_en;

endmodule

// File: tb/tb_m6502_bus_arbiter.sv
// Directed bench for m6502_bus_arbiter: one instance at RD_LATENCY=1 for the
// main scenarios, one at RD_LATENCY=3 for reset during a read countdown.
module tb_m6502_bus_arbiter;
    import m6502_bus_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wr_data;
    logic        cpu_rd_req;
    logic        cpu_wr_en;
    logic        dma_req;
    logic        dma_we;
    logic [15:0] dma_addr;
    logic [7:0]  dma_wr_data;
    logic [7:0]  mem_rd_data;
    logic        mem_ready;

    logic [7:0]  cpu_rd_data, dma_rd_data, mem_wr_data;
    logic        cpu_ready, dma_ack, mem_rd_req, mem_wr_en;
    logic [15:0] mem_addr;

    logic [7:0]  l3_cpu_rd_data, l3_dma_rd_data, l3_mem_wr_data;
    logic        l3_cpu_ready, l3_dma_ack, l3_mem_rd_req, l3_mem_wr_en;
    logic [15:0] l3_mem_addr;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    m6502_bus_arbiter #(.RD_LATENCY(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_data(cpu_rd_data), .cpu_ready(cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wr_data(dma_wr_data), .dma_rd_data(dma_rd_data), .dma_ack(dma_ack),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_req(mem_rd_req), .mem_wr_en(mem_wr_en),
        .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
    );

    m6502_bus_arbiter #(.RD_LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n),
        .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
        .cpu_rd_req(cpu_rd_req), .cpu_wr_en(cpu_wr_en),
        .cpu_rd_data(l3_cpu_rd_data), .cpu_ready(l3_cpu_ready),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wr_data(dma_wr_data), .dma_rd_data(l3_dma_rd_data), .dma_ack(l3_dma_ack),
        .mem_addr(l3_mem_addr), .mem_wr_data(l3_mem_wr_data),
        .mem_rd_req(l3_mem_rd_req), .mem_wr_en(l3_mem_wr_en),
        .mem_rd_data(mem_rd_data), .mem_ready(mem_ready)
    );

    // Advance one rising edge and park on the following falling edge.
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset;
        reset_n = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        tests_run++;
        if (cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cpu_ready: got %b want 1", cpu_ready); end
        tests_run++;
        if (dma_ack !== 1'b0) begin tests_failed++; $display("FAIL reset_dma_ack: got %b want 0", dma_ack); end
        tests_run++;
        if ({mem_rd_req, mem_wr_en} !== 2'b00) begin tests_failed++; $display("FAIL reset_strobes: got %b want 00", {mem_rd_req, mem_wr_en}); end
        tests_run++;
        if (mem_addr !== 16'h0000) begin tests_failed++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
        tests_run++;
        if (mem_wr_data !== 8'h00) begin tests_failed++; $display("FAIL reset_mem_wr_data: got %h want 00", mem_wr_data); end
        tests_run++;
        if ({cpu_rd_data, dma_rd_data} !== 16'h0000) begin tests_failed++; $display("FAIL reset_rd_data: got %h/%h want 00/00", cpu_rd_data, dma_rd_data); end
        tests_run++;
        if (dut.r_state !== ST_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dut.r_state, ST_IDLE); end
        tests_run++;
        if (dut.r_last_grant !== PORT_DMA) begin tests_failed++; $display("FAIL reset_last_grant: got %b want %b", dut.r_last_grant, PORT_DMA); end
    endtask

    // CPU read 0x1234 returning 0x5A, then hold of data and address.
    task automatic test_cpu_read;
        int low_cnt = 0;
        int rd_cnt  = 0;
        int bad_addr = 0;
        int ack_cnt = 0;
        mem_rd_data = 8'h5A;
        cpu_addr    = 16'h1234;
        cpu_rd_req  = 1'b1;
        tick();
        cpu_rd_req  = 1'b0;
        cpu_addr    = 16'hBEEF;
        for (int i = 0; i < 6; i++) begin
            if (!cpu_ready) low_cnt++;
            if (mem_rd_req) begin
                rd_cnt++;
                if (mem_addr !== 16'h1234) bad_addr++;
            end
            if (dma_ack) ack_cnt++;
            tick();
        end
        tests_run++;
        if (low_cnt != 2) begin tests_failed++; $display("FAIL cpu_read_ready_low: got %0d cycles want 2", low_cnt); end
        tests_run++;
        if (rd_cnt != 1 || bad_addr != 0) begin tests_failed++; $display("FAIL cpu_read_strobe: got %0d cycles (%0d bad addr) want 1 at 1234", rd_cnt, bad_addr); end
        tests_run++;
        if (cpu_rd_data !== 8'h5A) begin tests_failed++; $display("FAIL cpu_read_data: got %h want 5a", cpu_rd_data); end
        tests_run++;
        if (ack_cnt != 0) begin tests_failed++; $display("FAIL cpu_read_no_dma_ack: got %0d pulses want 0", ack_cnt); end
        mem_rd_data = 8'hEE;
        tick();
        tick();
        tests_run++;
        if (cpu_rd_data !== 8'h5A) begin tests_failed++; $display("FAIL cpu_read_hold: got %h want 5a", cpu_rd_data); end
        tests_run++;
        if (mem_addr !== 16'h1234) begin tests_failed++; $display("FAIL idle_addr_hold: got %h want 1234", mem_addr); end
    endtask

    // CPU write and DMA read on the same edge: CPU first, DMA back-to-back.
    task automatic test_back_to_back;
        int wr_cyc = -1;
        int rd_cyc = -1;
        int ack_cnt = 0;
        int both = 0;
        logic [15:0] wr_addr = 16'h0;
        logic [7:0]  wr_data = 8'h0;
        logic [15:0] rd_addr = 16'h0;
        mem_rd_data = 8'hC3;
        cpu_addr    = 16'h0200;
        cpu_wr_data = 8'h77;
        cpu_wr_en   = 1'b1;
        dma_addr    = 16'h8000;
        dma_we      = 1'b0;
        dma_req     = 1'b1;
        tick();
        cpu_wr_en = 1'b0;
        dma_req   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (mem_wr_en && mem_rd_req) both++;
            if (mem_wr_en && wr_cyc < 0) begin wr_cyc = i; wr_addr = mem_addr; wr_data = mem_wr_data; end
            if (mem_rd_req && rd_cyc < 0) begin rd_cyc = i; rd_addr = mem_addr; end
            if (dma_ack) ack_cnt++;
            tick();
        end
        tests_run++;
        if (wr_cyc != 0 || wr_addr !== 16'h0200 || wr_data !== 8'h77) begin tests_failed++; $display("FAIL b2b_cpu_write: got cyc %0d %h<=%h want cyc 0 0200<=77", wr_cyc, wr_addr, wr_data); end
        tests_run++;
        if (rd_cyc != 1 || rd_addr !== 16'h8000) begin tests_failed++; $display("FAIL b2b_dma_read: got cyc %0d addr %h want cyc 1 addr 8000", rd_cyc, rd_addr); end
        tests_run++;
        if (both != 0) begin tests_failed++; $display("FAIL b2b_one_strobe: got %0d cycles with both strobes want 0", both); end
        tests_run++;
        if (ack_cnt != 1) begin tests_failed++; $display("FAIL b2b_dma_ack: got %0d pulses want 1", ack_cnt); end
        tests_run++;
        if (dma_rd_data !== 8'hC3) begin tests_failed++; $display("FAIL b2b_dma_data: got %h want c3", dma_rd_data); end
        tests_run++;
        if (cpu_rd_data !== 8'h00 || cpu_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_cpu_side: got data %h ready %b want 00 1", cpu_rd_data, cpu_ready); end
    endtask

    // Level DMA request for 4 accesses against a CPU re-reading on every ready.
    task automatic test_round_robin;
        int seq[16];
        int n = 0;
        int acks = 0;
        int cpu_iss = 0;
        int bad = 0;
        bit done = 1'b0;
        mem_rd_data = 8'h11;
        dma_we      = 1'b0;
        dma_addr    = 16'h8000;
        dma_req     = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (mem_rd_req && n < 16) begin seq[n] = int'(mem_addr[15]); n++; end
            if (dma_ack) begin
                acks++;
                dma_addr = 16'h8000 + 16'(acks);
                if (acks >= 4) dma_req = 1'b0;
            end
            if (cpu_ready && cpu_iss < 4) begin
                cpu_rd_req = 1'b1;
                cpu_addr   = 16'h1000 + 16'(cpu_iss);
                cpu_iss++;
            end else begin
                cpu_rd_req = 1'b0;
            end
            if (acks == 4 && cpu_iss == 4 && cpu_ready) begin
                done = 1'b1;
                break;
            end
            tick();
        end
        cpu_rd_req = 1'b0;
        dma_req    = 1'b0;
        tests_run++;
        if (!done) begin tests_failed++; $display("FAIL rr_timeout: got %0d acks %0d cpu reads want 4 and 4", acks, cpu_iss); end
        tests_run++;
        if (n != 8) begin tests_failed++; $display("FAIL rr_grant_count: got %0d want 8", n); end
        for (int i = 0; i < n && i < 8; i++) begin
            if (seq[i] != (i % 2)) bad++;
        end
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL rr_alternate: got %0d %0d %0d %0d %0d %0d %0d %0d want 0 1 0 1 0 1 0 1 (0=cpu)",
                     seq[0], seq[1], seq[2], seq[3], seq[4], seq[5], seq[6], seq[7]);
        end
        tests_run++;
        if (dma_rd_data !== 8'h11) begin tests_failed++; $display("FAIL rr_dma_data: got %h want 11", dma_rd_data); end
    endtask

    // mem_ready low for 3 edges during a CPU read.
    task automatic test_mem_stall;
        int bad = 0;
        mem_rd_data = 8'hA7;
        mem_ready   = 1'b0;
        cpu_addr    = 16'h4321;
        cpu_rd_req  = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        cpu_addr   = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            if (mem_rd_req !== 1'b1 || mem_addr !== 16'h4321) bad++;
            if (i == 3) mem_ready = 1'b1;
            tick();
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL stall_stable: got %0d unstable cycles want 0 of 4", bad); end
        tests_run++;
        if (mem_rd_req !== 1'b0 || cpu_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_accept: got rd_req %b ready %b want 0 0", mem_rd_req, cpu_ready); end
        tick();
        tests_run++;
        if (cpu_ready !== 1'b1 || cpu_rd_data !== 8'hA7) begin tests_failed++; $display("FAIL stall_complete: got ready %b data %h want 1 a7", cpu_ready, cpu_rd_data); end
    endtask

    // Reset asserted while the RD_LATENCY=3 instance counts down a read.
    task automatic test_reset_in_wait;
        int bad = 0;
        apply_reset();
        mem_ready  = 1'b1;
        cpu_addr   = 16'h2468;
        cpu_rd_req = 1'b1;
        dma_addr   = 16'h9000;
        dma_we     = 1'b0;
        dma_req    = 1'b1;
        tick();
        cpu_rd_req = 1'b0;
        dma_req    = 1'b0;
        tests_run++;
        if (l3_mem_rd_req !== 1'b1 || l3_mem_addr !== 16'h2468) begin tests_failed++; $display("FAIL l3_issue: got rd_req %b addr %h want 1 2468", l3_mem_rd_req, l3_mem_addr); end
        tick();
        tests_run++;
        if (dut3.r_state !== ST_WAIT) begin tests_failed++; $display("FAIL l3_in_wait: got %0d want %0d", dut3.r_state, ST_WAIT); end
        reset_n = 1'b0;
        tick();
        tests_run++;
        if ({l3_mem_rd_req, l3_mem_wr_en} !== 2'b00) begin tests_failed++; $display("FAIL l3_reset_strobes: got %b want 00", {l3_mem_rd_req, l3_mem_wr_en}); end
        tests_run++;
        if (l3_cpu_ready !== 1'b1 || l3_dma_ack !== 1'b0) begin tests_failed++; $display("FAIL l3_reset_handshake: got ready %b ack %b want 1 0", l3_cpu_ready, l3_dma_ack); end
        tests_run++;
        if (dut3.r_state !== ST_IDLE) begin tests_failed++; $display("FAIL l3_reset_state: got %0d want %0d", dut3.r_state, ST_IDLE); end
        reset_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (l3_dma_ack || l3_mem_rd_req || !l3_cpu_ready) bad++;
            tick();
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL l3_abort_quiet: got %0d active cycles want 0", bad); end
    endtask

    initial begin
        reset_n     = 1'b0;
        cpu_addr    = 16'h0000;
        cpu_wr_data = 8'h00;
        cpu_rd_req  = 1'b0;
        cpu_wr_en   = 1'b0;
        dma_req     = 1'b0;
        dma_we      = 1'b0;
        dma_addr    = 16'h0000;
        dma_wr_data = 8'h00;
        mem_rd_data = 8'h00;
        mem_ready   = 1'b1;
        @(negedge clk);
        tick();
        tick();
        test_reset();
        reset_n = 1'b1;
        test_cpu_read();
        apply_reset();
        test_back_to_back();
        test_round_robin();
        tick();
        tick();
        test_mem_stall();
        test_reset_in_wait();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
